// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multicycle RISC-V control unit and its ALU:
// state codes, opcode constants, ALUControl encodings and mux select values.
package control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    // What the FSM asks of the ALU decoder; FUNCT defers to funct3/funct7b5.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Moore control word produced per state before reset masking.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
    } ctrl_t;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        imm = IMM_I;
        case (op)
            OP_SW:     imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control strobes out.
// All strobes are level signals valid for the whole cycle; there is no handshake.
interface control_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       IllegalOp;
    logic [3:0] State;

    // Controller side.
    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp, State
    );

    // Datapath side.
    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp, State
    );
endinterface

// File: rtl/control_fsm_alu_decoder.sv
// Maps the FSM's ALU request and the instruction funct fields to ALUControl.
module alu_decoder
    import control_fsm_pkg::*;
(
    input  alu_op_t    i_alu_op,
    input  logic       i_op5,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALUC_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALUC_ADD;
            ALUOP_SUB: o_alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type with funct7b5 subtracts; addi ignores bit 30.
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  o_alu_control = ALUC_SLT;
                    3'b110:  o_alu_control = ALUC_OR;
                    3'b111:  o_alu_control = ALUC_AND;
                    default: o_alu_control = ALUC_ADD;
                endcase
            end
            default: o_alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode and
// per-class execute steps, with branch resolution folded into PCWrite.
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    control_fsm_if.master ctrl_bus
);

    state_t     r_state;
    state_t     w_next_state;
    state_t     w_eff_state;
    ctrl_t      w_ctrl;
    logic [2:0] w_alu_control;
    logic       w_branch_taken;

    // While reset is held the outputs already show FETCH, so the datapath
    // sees a consistent control word instead of a stale mid-instruction one.
    assign w_eff_state = rst ? S_FETCH : r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                case (ctrl_bus.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTER;
                    OP_ITYPE:     w_next_state = S_EXECUTEI;
                    OP_BRANCH:    w_next_state = S_BRANCH;
                    OP_JAL:       w_next_state = S_JAL;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (ctrl_bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_JAL:      w_next_state = S_ALUWB;
            default:    w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        case (w_eff_state)
            S_FETCH: begin
                w_ctrl.ir_write   = 1'b1;
                w_ctrl.pc_update  = 1'b1;
                w_ctrl.alu_src_a  = SRCA_PC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALU;
                w_ctrl.alu_op     = ALUOP_ADD;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.illegal   = !op_supported(ctrl_bus.op);
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = SRCA_REG;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.result_src = RES_DATA;
                w_ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.adr_src    = 1'b1;
                w_ctrl.mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                w_ctrl.alu_src_a = SRCA_REG;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                w_ctrl.alu_src_a = SRCA_REG;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a  = SRCA_REG;
                w_ctrl.alu_src_b  = SRCB_REG;
                w_ctrl.alu_op     = ALUOP_SUB;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.branch     = 1'b1;
            end
            S_JAL: begin
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.alu_op     = ALUOP_ADD;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.pc_update  = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_ctrl.alu_op),
        .i_op5         (ctrl_bus.op[5]),
        .i_funct3      (ctrl_bus.funct3),
        .i_funct7b5    (ctrl_bus.funct7b5),
        .o_alu_control (w_alu_control)
    );

    // funct3[0] distinguishes bne from beq, so it inverts the Zero test.
    assign w_branch_taken = w_ctrl.branch & (ctrl_bus.Zero ^ ctrl_bus.funct3[0]);

    assign ctrl_bus.PCWrite    = !rst & (w_ctrl.pc_update | w_branch_taken);
    assign ctrl_bus.IRWrite    = !rst & w_ctrl.ir_write;
    assign ctrl_bus.RegWrite   = !rst & w_ctrl.reg_write;
    assign ctrl_bus.MemWrite   = !rst & w_ctrl.mem_write;
    assign ctrl_bus.IllegalOp  = !rst & w_ctrl.illegal;
    assign ctrl_bus.AdrSrc     = w_ctrl.adr_src;
    assign ctrl_bus.ResultSrc  = w_ctrl.result_src;
    assign ctrl_bus.ALUSrcA    = w_ctrl.alu_src_a;
    assign ctrl_bus.ALUSrcB    = w_ctrl.alu_src_b;
    assign ctrl_bus.ImmSrc     = imm_src_of(ctrl_bus.op);
    assign ctrl_bus.ALUControl = w_alu_control;
    assign ctrl_bus.State      = w_eff_state;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-instruction expected traces built from the
// instruction-class rules, compared cycle by cycle against the DUT outputs.
module tb_control_fsm;
    import control_fsm_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cnt_mw;
    int   cnt_rw;

    // Per-cycle expected word:
    // {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    //  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp}
    logic [20:0] exp_q[$];

    control_fsm_if bus ();

    control_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] pack(
        input logic [3:0] st, input logic pcw, input logic adr, input logic mw,
        input logic irw, input logic rw, input logic [1:0] res, input logic [1:0] sa,
        input logic [1:0] sb, input logic [1:0] imm, input logic [2:0] aluc,
        input logic ill);
        return {st, pcw, adr, mw, irw, rw, res, sa, sb, imm, aluc, ill};
    endfunction

    function automatic logic [20:0] got_vec();
        return {bus.State, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                bus.ALUControl, bus.IllegalOp};
    endfunction

    // Immediate format by instruction type.
    function automatic logic [1:0] m_imm(input logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // ALU operation an R/I arithmetic instruction asks for.
    function automatic logic [2:0] m_arith(input logic is_r, input logic [2:0] f3, input logic f7);
        if (f3 == 3'b000) return (is_r && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic logic [20:0] reset_vec(input logic [6:0] op);
        return pack(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, m_imm(op), 3'b000, 0);
    endfunction

    // Expected cycle-by-cycle trace for one instruction, by instruction class.
    task automatic build_trace(input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input logic z);
        logic [1:0] imm;
        logic       legal;
        logic       taken;
        imm   = m_imm(op);
        legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
        taken = f3[0] ? !z : z;
        exp_q.push_back(pack(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0));
        exp_q.push_back(pack(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, !legal));
        if (op == OP_LW) begin
            exp_q.push_back(pack(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0));
            exp_q.push_back(pack(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0));
            exp_q.push_back(pack(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, imm, 3'b000, 0));
        end else if (op == OP_SW) begin
            exp_q.push_back(pack(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0));
            exp_q.push_back(pack(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0));
        end else if (op == OP_RTYPE) begin
            exp_q.push_back(pack(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, m_arith(1, f3, f7), 0));
            exp_q.push_back(pack(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0));
        end else if (op == OP_ITYPE) begin
            exp_q.push_back(pack(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, m_arith(0, f3, f7), 0));
            exp_q.push_back(pack(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0));
        end else if (op == OP_BRANCH) begin
            exp_q.push_back(pack(4'd9, taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, 3'b001, 0));
        end else if (op == OP_JAL) begin
            exp_q.push_back(pack(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, 3'b000, 0));
            exp_q.push_back(pack(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0));
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.Zero     = z;
    endtask

    // Compare n cycles of the queued trace; enter and leave just after a negedge.
    task automatic run_n(input string name, input int n);
        logic [20:0] e;
        logic [20:0] g;
        for (int i = 0; i < n; i++) begin
            #1;
            e = exp_q.pop_front();
            g = got_vec();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, g, e);
            end
            if (bus.MemWrite) cnt_mw++;
            if (bus.RegWrite) cnt_rw++;
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z);
        set_instr(op, f3, f7, z);
        exp_q.delete();
        build_trace(op, f3, f7, z);
        run_n(name, exp_q.size());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (got_vec() !== reset_vec(bus.op)) begin
                n_fail++;
                $display("FAIL reset_hold: got %h expected %h", got_vec(), reset_vec(bus.op));
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (got_vec() !== pack(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0)) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected FETCH with IRWrite=1", got_vec());
        end
    endtask

    task automatic test_rtype_sub();
        run_instr("rtype_sub", OP_RTYPE, 3'b000, 1'b1, 1'b0);
    endtask

    task automatic test_lw();
        run_instr("lw", OP_LW, 3'b010, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", OP_BRANCH, 3'b000, 1'b0, 1'b1);
        run_instr("beq_not_taken", OP_BRANCH, 3'b000, 1'b0, 1'b0);
        run_instr("bne_not_taken", OP_BRANCH, 3'b001, 1'b0, 1'b1);
        run_instr("bne_taken", OP_BRANCH, 3'b001, 1'b0, 1'b0);
    endtask

    task automatic test_sw();
        cnt_mw = 0;
        cnt_rw = 0;
        run_instr("sw", OP_SW, 3'b010, 1'b0, 1'b0);
        n_tests++;
        if (cnt_mw !== 1) begin
            n_fail++;
            $display("FAIL sw_memwrite_cycles: got %0d required 1", cnt_mw);
        end
        n_tests++;
        if (cnt_rw !== 0) begin
            n_fail++;
            $display("FAIL sw_regwrite_cycles: got %0d required 0", cnt_rw);
        end
    endtask

    task automatic test_illegal();
        run_instr("illegal", 7'b0000000, 3'b000, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (bus.State !== 4'd0 || bus.IllegalOp !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_return: got State=%0d IllegalOp=%b required State=0 IllegalOp=0",
                     bus.State, bus.IllegalOp);
        end
    endtask

    task automatic test_reset_mid();
        logic [20:0] e;
        set_instr(OP_LW, 3'b010, 1'b0, 1'b0);
        exp_q.delete();
        build_trace(OP_LW, 3'b010, 1'b0, 1'b0);
        run_n("reset_mid_pre", 3);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if (got_vec() !== e) begin
            n_fail++;
            $display("FAIL reset_mid_memread: got %h expected %h", got_vec(), e);
        end
        exp_q.delete();
        rst = 1'b1;
        #1;
        n_tests++;
        if (got_vec() !== reset_vec(OP_LW)) begin
            n_fail++;
            $display("FAIL reset_mid_asserted: got %h expected %h", got_vec(), reset_vec(OP_LW));
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (got_vec() !== reset_vec(OP_LW)) begin
            n_fail++;
            $display("FAIL reset_mid_after_edge: got %h expected %h", got_vec(), reset_vec(OP_LW));
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.State !== 4'd0 || bus.IRWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_release: got State=%0d IRWrite=%b required State=0 IRWrite=1",
                     bus.State, bus.IRWrite);
        end
        run_instr("reset_mid_resume", OP_ITYPE, 3'b110, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] ops[6];
        logic [6:0] op;
        ops[0] = OP_LW;     ops[1] = OP_SW;     ops[2] = OP_RTYPE;
        ops[3] = OP_ITYPE;  ops[4] = OP_BRANCH; ops[5] = OP_JAL;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 4) == 0) op = 7'($urandom_range(0, 127));
            else op = ops[$urandom_range(0, 5)];
            run_instr("random", op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cnt_mw  = 0;
        cnt_rw  = 0;
        test_reset();
        test_rtype_sub();
        test_lw();
        test_branch();
        test_sw();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
